uart_transmitter: RTL

//  Serial UART transmitter for the multicycle I/O system: the sending end of the RsTx/RsRx line.

---
 rtl/uart_pkg.sv | 12 +
 rtl/baud_timer.sv | 32 +++
 rtl/uart_transmitter.sv | 97 +++++++++
 3 files changed

// File: rtl/uart_pkg.sv
// Shared types and helpers for the UART transmit/receive pair.
package uart_pkg;

  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} uart_tx_state_t;

  localparam int DATA_BITS = 8;

  function automatic int baud_clocks(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/baud_timer.sv
// Bit-period timer: counts 0..BAUD_CLOCKS-1 and flags the terminal count.
module baud_timer #(
  parameter int BAUD_CLOCKS = 10
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  output logic tick,
  output logic pre_tick
);

  localparam int CW = $clog2(BAUD_CLOCKS);
  localparam logic [CW-1:0] LAST = CW'(BAUD_CLOCKS - 1);
  localparam logic [CW-1:0] PRE  = CW'(BAUD_CLOCKS - 2);

  logic [CW-1:0] cnt_q, cnt_d;

  assign tick     = (cnt_q == LAST);
  // Lets the owner register a flag that lands on the final cycle of a bit.
  assign pre_tick = (cnt_q == PRE);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    if (clear || tick) cnt_d = '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

endmodule

// File: rtl/uart_transmitter.sv
// 8-N-1 UART transmitter with optional parity; every output is a flop.
module uart_transmitter
  import uart_pkg::*;
#(
  parameter int CLK_FREQUENCY = 100_000_000,
  parameter int BAUD_RATE     = 19_200,
  parameter bit PARITY_EN     = 1'b0,
  parameter bit PARITY_ODD    = 1'b0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       send,
  input  logic [7:0] din,
  output logic       busy,
  output logic       tx_done,
  output logic       tx_out
);

  localparam int BAUD_CLOCKS = baud_clocks(CLK_FREQUENCY, BAUD_RATE);

  uart_tx_state_t       state_q;
  logic [DATA_BITS-1:0] shift_q;
  logic [2:0]           bit_cnt_q;
  logic                 parity_q, tx_q, busy_q, done_q;
  logic                 accept, tick, pre_tick;

  assign accept = (state_q == IDLE) && send;

  baud_timer #(.BAUD_CLOCKS(BAUD_CLOCKS)) u_baud (
    .clk      (clk),
    .rst      (rst),
    .clear    (accept),
    .tick     (tick),
    .pre_tick (pre_tick)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      bit_cnt_q <= '0;
      parity_q  <= 1'b0;
      tx_q      <= 1'b1;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        IDLE: if (send) begin
          shift_q  <= din;
          parity_q <= (^din) ^ PARITY_ODD;
          state_q  <= START;
          tx_q     <= 1'b0;
          busy_q   <= 1'b1;
        end
        START: if (tick) begin
          state_q   <= DATA;
          bit_cnt_q <= '0;
          tx_q      <= shift_q[0];
        end
        DATA: if (tick) begin
          if (bit_cnt_q == 3'(DATA_BITS - 1)) begin
            if (PARITY_EN) begin
              state_q <= PARITY;
              tx_q    <= parity_q;
            end else begin
              state_q <= STOP;
              tx_q    <= 1'b1;
            end
          end else begin
            // Drive the bit that becomes shift[0] after this shift.
            shift_q   <= shift_q >> 1;
            tx_q      <= shift_q[1];
            bit_cnt_q <= bit_cnt_q + 3'd1;
          end
        end
        PARITY: if (tick) begin
          state_q <= STOP;
          tx_q    <= 1'b1;
        end
        STOP: begin
          done_q <= pre_tick;
          if (tick) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign tx_out  = tx_q;
  assign busy    = busy_q;
  assign tx_done = done_q;

endmodule
